// File: rtl/hdmi_cfg_sequencer_if.sv
// Byte-write request/response bus between the HDMI config sequencer and an I2C byte-write master.
interface hdmi_cfg_sequencer_if;
  logic       WR_REQ;
  logic [7:0] WR_REG;
  logic [7:0] WR_DATA;
  logic       WR_ACK;
  logic       WR_NACK;

  modport master (
    output WR_REQ,
    output WR_REG,
    output WR_DATA,
    input  WR_ACK,
    input  WR_NACK
  );

  modport slave (
    input  WR_REQ,
    input  WR_REG,
    input  WR_DATA,
    output WR_ACK,
    output WR_NACK
  );
endinterface

// File: rtl/hdmi_cfg_sequencer.sv
// HDMI transmitter register-table sequencer: writes a fixed 12-entry table after power-up, retrying NACKed writes.
// Hot-plug re-initialisation on TX_INT_N is compiled in only when HDMI_CFG_HPD_REINIT_EN is defined.
module hdmi_cfg_sequencer #(
  parameter int unsigned STARTUP_CYCLES = 10_000_000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned RETRY_CYCLES   = 50_000
) (
  input  logic                 CLK_50MHZ,
  input  logic                 RESET_N,
  input  logic                 TX_INT_N,
  hdmi_cfg_sequencer_if.master wr,
  output logic                 CFG_DONE,
  output logic                 CFG_ERROR,
  output logic                 CFG_BUSY
);

  localparam int unsigned   CW           = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam int unsigned   RW           = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX      = '1;
  localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_CYCLES - 1);
  localparam logic [CW-1:0] RETRY_LAST   = CW'(RETRY_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);
  localparam logic [3:0]    LAST_PTR     = 4'd11;

  typedef enum logic [2:0] {
    WAIT_PWR,
    ISSUE,
    WAIT_RSP,
    BACKOFF,
    DONE,
    FAIL
  } state_e;

  function automatic logic [15:0] tableEntry(input logic [3:0] idx);
    case (idx)
      4'd0:    tableEntry = 16'h41_10;
      4'd1:    tableEntry = 16'h98_03;
      4'd2:    tableEntry = 16'h9A_E0;
      4'd3:    tableEntry = 16'h9C_30;
      4'd4:    tableEntry = 16'h9D_61;
      4'd5:    tableEntry = 16'hA2_A4;
      4'd6:    tableEntry = 16'hA3_A4;
      4'd7:    tableEntry = 16'hE0_D0;
      4'd8:    tableEntry = 16'hF9_00;
      4'd9:    tableEntry = 16'h15_00;
      4'd10:   tableEntry = 16'h16_30;
      4'd11:   tableEntry = 16'hAF_06;
      default: tableEntry = 16'h00_00;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    ptr_q, ptr_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          busy_q, busy_d;
  logic          reloadReq;

`ifdef HDMI_CFG_HPD_REINIT_EN
  logic sync1_q, sync2_q, prev_q;
  logic pending_q, pending_d;
  logic hpdFall;

  always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      pending_q <= 1'b0;
    end else begin
      sync1_q   <= TX_INT_N;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
    end
  end

  assign hpdFall = prev_q & ~sync2_q;

  // A hot-plug seen mid-sequence is remembered so the table is rewritten as soon as DONE is reached.
  always_comb begin
    pending_d = pending_q;
    if (state_q == DONE || state_q == FAIL) begin
      pending_d = 1'b0;
    end else if (hpdFall) begin
      pending_d = 1'b1;
    end
  end

  assign reloadReq = hpdFall | (pending_q & (state_q == DONE));
`else
  logic unusedTxInt;
  assign unusedTxInt = TX_INT_N;
  assign reloadReq   = 1'b0;
`endif

  always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= WAIT_PWR;
      ptr_q   <= '0;
      retry_q <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      reg_q   <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      error_q <= error_d;
      busy_q  <= busy_d;
    end
  end

  // A simultaneous ACK and NACK is resolved as a NACK by testing NACK first.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    retry_d = retry_q;
    case (state_q)
      WAIT_PWR: begin
        if (cnt_q == STARTUP_LAST) begin
          state_d = ISSUE;
          ptr_d   = '0;
        end
      end
      ISSUE: state_d = WAIT_RSP;
      WAIT_RSP: begin
        if (wr.WR_NACK) begin
          if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + 1'b1;
            state_d = BACKOFF;
          end else begin
            state_d = FAIL;
          end
        end else if (wr.WR_ACK) begin
          if (ptr_q == LAST_PTR) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            retry_d = '0;
            state_d = ISSUE;
          end
        end
      end
      BACKOFF: begin
        if (cnt_q == RETRY_LAST) state_d = ISSUE;
      end
      DONE, FAIL: begin
        if (reloadReq) begin
          state_d = BACKOFF;
          ptr_d   = '0;
          retry_d = '0;
        end
      end
      default: state_d = WAIT_PWR;
    endcase
    // The shared wait counter restarts on every state change and saturates instead of wrapping.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    req_d           = (state_d == ISSUE) || (state_d == WAIT_RSP);
    {reg_d, data_d} = req_d ? tableEntry(ptr_d) : 16'h0000;
    done_d          = (state_d == DONE);
    error_d         = (state_d == FAIL);
    busy_d          = !(done_d || error_d);
  end

  assign wr.WR_REQ  = req_q;
  assign wr.WR_REG  = reg_q;
  assign wr.WR_DATA = data_q;
  assign CFG_DONE   = done_q;
  assign CFG_ERROR  = error_q;
  assign CFG_BUSY   = busy_q;

endmodule

// File: doc/hdmi_cfg_sequencer.md
HDMI_CFG_SEQUENCER -- requirements
Module: hdmi_cfg_sequencer

Interface
REQ-001 The module SHALL have parameter STARTUP_CYCLES, default 10_000_000, meaning the power-up wait before the first write (200 ms at 50 MHz).
REQ-002 The module SHALL have parameter MAX_RETRY, default 3, meaning the number of retries allowed per register after a NACK.
REQ-003 The module SHALL have parameter RETRY_CYCLES, default 50_000, meaning the back-off delay before a retry (1 ms).
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-005 CLK_50MHZ  in  1  sole clock; all state is updated on its rising edge.
REQ-006 RESET_N  in  1  asynchronous, active-low reset.
REQ-007 TX_INT_N  in  1  HDMI transmitter interrupt/hot-plug line, active low, asynchronous to CLK_50MHZ.
REQ-008 WR_REQ  out  1  request to the I2C byte-write master, level-held until accepted.
REQ-009 WR_REG  out  8  transmitter register address.
REQ-010 WR_DATA  out  8  register value.
REQ-011 WR_ACK  in  1  one-cycle pulse: write completed and the slave ACKed.
REQ-012 WR_NACK  in  1  one-cycle pulse: write completed and the slave NACKed.
REQ-013 CFG_DONE  out  1  high while the full table has been written successfully.
REQ-014 CFG_ERROR  out  1  high after the retry limit is exhausted.
REQ-015 CFG_BUSY  out  1  high from the start of the power-up wait until DONE or FAIL.

Function
REQ-016 The module SHALL hold a fixed 12-entry table of {reg, value} pairs, indexed by a 4-bit pointer, in this order: 41=10, 98=03, 9A=E0, 9C=30, 9D=61, A2=A4, A3=A4, E0=D0, F9=00, 15=00, 16=30, AF=06.
REQ-017 The state machine SHALL have the states WAIT_PWR, ISSUE, WAIT_RSP, BACKOFF, DONE and FAIL.
REQ-018 On leaving reset, the state machine SHALL enter WAIT_PWR with the cycle counter at 0.
REQ-019 WAIT_PWR SHALL go to ISSUE when the counter equals STARTUP_CYCLES-1, with the pointer at 0.
REQ-020 In ISSUE, WR_REQ SHALL be 1, WR_REG/WR_DATA SHALL be the table entry at the pointer, and the next cycle SHALL be WAIT_RSP.
REQ-021 WR_REQ SHALL stay high through WAIT_RSP, and WR_REG/WR_DATA SHALL stay stable until WR_ACK or WR_NACK arrives.
REQ-022 On WR_ACK at pointer 11, the state machine SHALL go to DONE; on WR_ACK at any other pointer, it SHALL increment the pointer, clear the retry count and go to ISSUE.
REQ-023 On WR_NACK with retry count < MAX_RETRY, the module SHALL increment the retry count and go to BACKOFF; BACKOFF SHALL wait RETRY_CYCLES and then return to ISSUE with the same pointer.
REQ-024 On WR_NACK with retry count = MAX_RETRY, the state machine SHALL go to FAIL.
REQ-025 If WR_ACK and WR_NACK are asserted in the same cycle, the module SHALL treat the cycle as a NACK.
REQ-026 WR_ACK and WR_NACK SHALL be ignored outside WAIT_RSP.
REQ-027 DONE and FAIL SHALL be terminal except as described under Configuration; CFG_DONE = (state==DONE) and CFG_ERROR = (state==FAIL), both registered.
REQ-028 In DONE and FAIL, WR_REQ SHALL be 0.
REQ-029 Counter width SHALL be clog2(STARTUP_CYCLES), and the counter SHALL saturate without wrapping.
REQ-030 TX_INT_N SHALL pass through a 2-flop synchronizer; a falling edge is detected on the synchronized signal.

Reset
REQ-031 With RESET_N low, the outputs SHALL be: WR_REQ=0, WR_REG=00, WR_DATA=00, CFG_DONE=0, CFG_ERROR=0, CFG_BUSY=0; pointer, retry count and counter SHALL be 0; the synchronizer SHALL be 1.
REQ-032 Assertion of RESET_N mid-transaction SHALL drop WR_REQ immediately, and a later WR_ACK SHALL have no effect.
REQ-033 Release of RESET_N SHALL restart at WAIT_PWR.

Configuration
REQ-034 With HDMI_CFG_HPD_REINIT_EN defined, a synchronized falling edge on TX_INT_N in DONE or FAIL SHALL move the state machine to BACKOFF with pointer=0 and retry=0, so the full table is rewritten after RETRY_CYCLES.
REQ-035 With HDMI_CFG_HPD_REINIT_EN defined, a falling edge in any other state SHALL set a pending flag that triggers the reload on entry to DONE.
REQ-036 Without HDMI_CFG_HPD_REINIT_EN, TX_INT_N SHALL be ignored, and the synchronizer and edge logic SHALL not be compiled.

Verification
REQ-037 The bench SHALL cover: STARTUP_CYCLES=100, RETRY_CYCLES=20, slave ACKs 4 cycles after each request -> first WR_REQ in cycle 100 with 41/10, twelve writes in table order, CFG_DONE rises one cycle after the 12th ACK.
REQ-038 The bench SHALL cover: NACK on entry 3 (9C) twice, then ACK -> 9C reissued after 20-cycle back-offs, sequence completes, CFG_ERROR=0.
REQ-039 The bench SHALL cover: NACK on entry 0 four times with MAX_RETRY=3 -> FAIL after the 4th NACK, CFG_ERROR=1, WR_REQ=0, no further requests.
REQ-040 The bench SHALL cover: WR_ACK and WR_NACK asserted in the same cycle on entry 5 -> retry count 1, entry 5 reissued.
REQ-041 The bench SHALL cover: RESET_N pulsed low during WAIT_RSP of entry 7 -> WR_REQ=0 asynchronously; after release, the 100-cycle wait is followed by a restart at 41/10.
REQ-042 The bench SHALL cover, with the macro defined: TX_INT_N falling edge after DONE -> CFG_DONE drops and the full table is rewritten after 20 cycles; without the macro, the same stimulus leaves CFG_DONE=1 and issues no requests.
